// File: rtl/nibbler_pkg.sv
// Shared definitions for the Nibbler fetch/phase sequencer:
// opcode and phase encodings, control-word bit positions.
package nibbler_pkg;

  typedef enum logic [3:0] {
    JC   = 4'h0,
    JNC  = 4'h1,
    CMPI = 4'h2,
    CMPM = 4'h3,
    LIT  = 4'h4,
    IN   = 4'h5,
    LD   = 4'h6,
    ST   = 4'h7,
    JZ   = 4'h8,
    JNZ  = 4'h9,
    ADDI = 4'hA,
    ADDM = 4'hB,
    JMP  = 4'hC,
    OUT  = 4'hD,
    NORI = 4'hE,
    NORM = 4'hF
  } op_e;

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } phase_e;

  localparam int CTRL_LOADPC_BIT  = 14;
  localparam int CTRL_LOADFLG_BIT = 4;

  // Opcodes followed by an operand/address byte.
  function automatic logic is_two_byte(input op_e op);
    unique case (op)
      JC, JNC, CMPM, LD, ST,
      JZ, JNZ, ADDM, JMP, NORM: is_two_byte = 1'b1;
      default:                  is_two_byte = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/nibbler_pc.sv
// Program counter: load has priority over increment,
// increment wraps modulo 2^PC_W.
module nibbler_pc
  import nibbler_pkg::*;
#(
  parameter int PC_W = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc,
  input  logic            load,
  input  logic [PC_W-1:0] load_val,
  output logic [PC_W-1:0] pc
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + 1'b1;
    end
  end

endmodule

// File: rtl/nibbler_fetch_seq.sv
// Fetch/phase sequencer feeding the control ROM: owns PC,
// phase, IR and the active-low carry/zero flags.
module nibbler_fetch_seq
  import nibbler_pkg::*;
#(
  parameter int PC_W        = 12,
  parameter int INSTR_W     = 8,
  parameter int CTRL_W      = 16,
  parameter int LOADPC_BIT  = CTRL_LOADPC_BIT,
  parameter int LOADFLG_BIT = CTRL_LOADFLG_BIT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               step_en,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic [CTRL_W-1:0]  ctrl_word,
  input  logic               alu_c,
  input  logic               alu_z,
  output logic [PC_W-1:0]    prog_addr,
  output logic [6:0]         ctrl_addr,
  output logic [3:0]         operand,
  output logic [PC_W-1:0]    mem_addr,
  output logic               phase
);

  phase_e             phase_q;
  phase_e             phase_nxt;
  logic [INSTR_W-1:0] ir;
  logic               c_n;
  logic               z_n;
  logic [PC_W-1:0]    pc;
  logic               fetch;
  logic               exec;
  logic               pc_inc;
  logic               pc_load;
  op_e                op;

  assign op    = op_e'(ir[7:4]);
  assign fetch = step_en && (phase_q == FETCH);
  assign exec  = step_en && (phase_q == EXEC);

  always_comb begin
    pc_load = 1'b0;
    pc_inc  = 1'b0;
    unique case (1'b1)
      fetch: pc_inc = 1'b1;
      exec: begin
        pc_load = !ctrl_word[LOADPC_BIT];
        pc_inc  = ctrl_word[LOADPC_BIT]
                  && is_two_byte(op);
      end
      default: ;
    endcase
  end

  always_comb begin
    phase_nxt = phase_q;
    unique case (1'b1)
      fetch:   phase_nxt = EXEC;
      exec:    phase_nxt = FETCH;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q <= FETCH;
    end else begin
      phase_q <= phase_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ir <= '0;
    end else if (fetch) begin
      ir <= prog_data;
    end
  end

  // Flags written here are seen by the next instruction's EXEC.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c_n <= 1'b1;
      z_n <= 1'b1;
    end else if (exec && !ctrl_word[LOADFLG_BIT]) begin
      c_n <= ~alu_c;
      z_n <= ~alu_z;
    end
  end

  nibbler_pc #(
    .PC_W(PC_W)
  ) u_pc (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (pc_inc),
    .load    (pc_load),
    .load_val(mem_addr),
    .pc      (pc)
  );

  assign prog_addr = pc;
  assign operand   = ir[3:0];
  assign mem_addr  = {ir[3:0], prog_data};
  assign phase     = phase_q;
  assign ctrl_addr = {ir[7:4], c_n, z_n, phase_q};

endmodule

// File: tb/tb_nibbler_fetch_seq.sv
// Self-checking bench for nibbler_fetch_seq: instruction-level
// model, directed scenarios and randomized stepping.
module tb_nibbler_fetch_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        step_en;
  logic [7:0]  prog_data;
  logic [15:0] ctrl_word;
  logic        alu_c;
  logic        alu_z;
  logic [11:0] prog_addr;
  logic [6:0]  ctrl_addr;
  logic [3:0]  operand;
  logic [11:0] mem_addr;
  logic        phase;

  logic [7:0] prog [4096];

  int errors = 0;
  int checks = 0;

  int         m_pc;
  bit         m_ph;
  logic [7:0] m_ir;
  bit         m_c;
  bit         m_z;
  bit         m_valid = 0;

  always #5 clk = ~clk;

  assign prog_data = prog[prog_addr];

  nibbler_fetch_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .step_en  (step_en),
    .prog_data(prog_data),
    .ctrl_word(ctrl_word),
    .alu_c    (alu_c),
    .alu_z    (alu_z),
    .prog_addr(prog_addr),
    .ctrl_addr(ctrl_addr),
    .operand  (operand),
    .mem_addr (mem_addr),
    .phase    (phase)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  function automatic bit two_byte(input logic [3:0] op);
    logic [15:0] mask;
    mask = 16'h9BCB;
    return mask[op];
  endfunction

  // Called at the negedge: drive, compare against model,
  // advance model, let the clock edge happen.
  task automatic step(input bit en, input bit rn,
                      input logic [15:0] cw,
                      input bit c, input bit z);
    logic [11:0] tgt;
    step_en   = en;
    rst_n     = rn;
    ctrl_word = cw;
    alu_c     = c;
    alu_z     = z;
    #1;
    if (m_valid) begin
      chk("prog_addr", 32'(prog_addr), 32'(m_pc));
      chk("phase", 32'(phase), 32'(m_ph));
      chk("operand", 32'(operand), 32'(m_ir[3:0]));
      chk("ctrl_addr", 32'(ctrl_addr),
          32'({m_ir[7:4], m_c, m_z, m_ph}));
      chk("mem_addr", 32'(mem_addr),
          32'({m_ir[3:0], prog[m_pc]}));
    end
    if (!rn) begin
      m_pc = 0; m_ph = 0; m_ir = 8'h00;
      m_c = 1; m_z = 1; m_valid = 1;
    end else if (en) begin
      if (!m_ph) begin
        m_ir = prog[m_pc];
        m_pc = (m_pc + 1) % 4096;
        m_ph = 1;
      end else begin
        tgt = {m_ir[3:0], prog[m_pc]};
        if (!cw[14])
          m_pc = int'(tgt);
        else if (two_byte(m_ir[7:4]))
          m_pc = (m_pc + 1) % 4096;
        if (!cw[4]) begin
          m_c = !c;
          m_z = !z;
        end
        m_ph = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    step(1, 0, 16'hFFFF, 0, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    step_en   = 1'b1;
    ctrl_word = 16'hFFFF;
    alu_c     = 1'b0;
    alu_z     = 1'b0;
    for (int i = 0; i < 4096; i++)
      prog[i] = 8'($urandom);
    @(negedge clk);

    // Reset held two cycles with step_en high
    do_reset();
    do_reset();
    chk("rst_pc", 32'(prog_addr), 32'h0);
    chk("rst_phase", 32'(phase), 32'h0);
    chk("rst_ctrl", 32'(ctrl_addr), 32'b0000110);
    chk("rst_operand", 32'(operand), 32'h0);

    // LIT 5: one-byte, PC holds after EXEC
    prog[0] = 8'h45;
    prog[1] = 8'h00;
    step(1, 1, 16'hFFFF, 0, 0);
    chk("lit_f_pc", 32'(prog_addr), 32'h1);
    chk("lit_f_op", 32'(ctrl_addr[6:3]), 32'h4);
    chk("lit_f_ph", 32'(phase), 32'h1);
    step(1, 1, 16'hFFFF, 0, 0);
    chk("lit_e_pc", 32'(prog_addr), 32'h1);
    chk("lit_e_opnd", 32'(operand), 32'h5);

    // JMP 3A7
    do_reset();
    prog[0] = 8'hC3;
    prog[1] = 8'hA7;
    step(1, 1, 16'hFFFF, 0, 0);
    chk("jmp_maddr", 32'(mem_addr), 32'h3A7);
    step(1, 1, 16'hBFFF, 0, 0);
    chk("jmp_pc", 32'(prog_addr), 32'h3A7);
    chk("jmp_ph", 32'(phase), 32'h0);

    // ADDI writes flags for the next instruction
    do_reset();
    prog[0] = 8'hA1;
    prog[1] = 8'h40;
    step(1, 1, 16'hFFFF, 0, 0);
    chk("addi_fl_pre", 32'(ctrl_addr[2:1]), 32'h3);
    step(1, 1, 16'hFFEF, 1, 0);
    chk("addi_fl", 32'(ctrl_addr[2:1]), 32'h1);
    chk("addi_pc", 32'(prog_addr), 32'h1);
    step(1, 1, 16'hFFFF, 0, 1);
    chk("next_fl", 32'(ctrl_addr), 32'b0100011);

    // PC wrap at FFF on a two-byte op
    do_reset();
    prog[0]     = 8'hCF;
    prog[1]     = 8'hFF;
    prog[12'hFFF] = 8'h60;
    step(1, 1, 16'hFFFF, 0, 0);
    step(1, 1, 16'hBFFF, 0, 0);
    chk("wrap_pre", 32'(prog_addr), 32'hFFF);
    step(1, 1, 16'hFFFF, 0, 0);
    chk("wrap_f", 32'(prog_addr), 32'h000);
    step(1, 1, 16'hFFFF, 0, 0);
    chk("wrap_e", 32'(prog_addr), 32'h001);

    // Stall mid-EXEC, then reset
    do_reset();
    prog[0] = 8'h45;
    step(1, 1, 16'hFFFF, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 16'($urandom), 1, 1);
      chk("stall_pc", 32'(prog_addr), 32'h1);
      chk("stall_ph", 32'(phase), 32'h1);
      chk("stall_ir", 32'(ctrl_addr[6:3]), 32'h4);
    end
    step(1, 0, 16'h0000, 1, 1);
    chk("srst_pc", 32'(prog_addr), 32'h0);
    chk("srst_ph", 32'(phase), 32'h0);
    chk("srst_fl", 32'(ctrl_addr[2:1]), 32'h3);

    // Randomized stepping against the model
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 9) < 8),
           ($urandom_range(0, 99) != 0),
           16'($urandom),
           1'($urandom), 1'($urandom));
    end
    step(0, 1, 16'hFFFF, 0, 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
